psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream stage of the 9-input XNOR-popcount kernel.
- Consumes the kernel's registered signed 5-bit partial sums (range -9..+9), one per beat.
- Accumulates the beats of one output neuron's dot product, terminated by a last flag.
- Applies a per-neuron threshold (folded batch-norm) to produce the binary activation for the next layer, plus the full-precision sum.
- Result is held in an output register under a valid/ready handshake.

Parameters:
- ACC_WIDTH, 16: width of the signed accumulator, threshold and acc_out (min 6).
- CNT_WIDTH, 12: width of the beat counter; max beats per vector is 2^CNT_WIDTH-1.

Ports:
- clk_in, input, 1: single clock; all logic on rising edge.
- reset_in, input, 1: synchronous, active-high reset.
- psum_valid_in, input, 1: psum_in/psum_last_in valid this cycle.
- psum_in, input, 5: signed two's-complement partial sum from the kernel.
- psum_last_in, input, 1: this beat is the final beat of the current vector.
- threshold_in, input, ACC_WIDTH: signed threshold; sampled only on the accepted last beat.
- psum_ready_out, output, 1: block accepts a beat this cycle.
- result_valid_out, output, 1: result register holds an unconsumed result.
- result_ready_in, input, 1: downstream consumes the result.
- acc_out, output, ACC_WIDTH: signed final sum of the vector.
- act_out, output, 1: 1 if acc_out >= threshold (activation +1), else 0 (-1).
- beat_count_out, output, CNT_WIDTH: number of beats in the completed vector.

Behaviour:
- Reset: synchronous, active-high, applied on a clk_in edge with reset_in=1. Clears the accumulator to 0, the beat counter to 0, state to EMPTY, result_valid_out to 0, acc_out to 0, act_out to 0 and beat_count_out to 0. Reset mid-vector discards the partial sum and any held result.
- Input handshake:
  - psum_ready_out = !result_valid_out || result_ready_in (combinational).
  - A beat is accepted when psum_valid_in && psum_ready_out.
- Arithmetic:
  - psum_in is sign-extended to ACC_WIDTH before the add; sum_next = acc + sext(psum_in).
  - Comparison is signed, with >= semantics.
- States: EMPTY (acc=0, no beats yet) and ACCUM (partial sum held).
  - EMPTY, accepted non-last beat: acc <= sext(psum_in), cnt <= 1, go to ACCUM.
  - ACCUM, accepted non-last beat: acc <= sum_next, cnt <= cnt+1.
  - Either state, accepted last beat:
    - acc_out <= sum_next (from EMPTY, sum_next = sext(psum_in));
    - act_out <= (sum_next >= threshold_in);
    - beat_count_out <= cnt+1;
    - result_valid_out <= 1;
    - acc <= 0, cnt <= 0, go to EMPTY.
  - A single-beat vector (last on the first beat) is legal.
- Latency: the result is visible the cycle after the last beat is accepted.
- Output handshake:
  - A result is consumed when result_valid_out && result_ready_in.
  - On consume with no new last beat, result_valid_out <= 0. Output data may hold stale values while valid is low.
  - Consume and a new last beat accepted in the same cycle: the new result overwrites and result_valid_out stays 1 (no bubble).
- Stall: while result_valid_out=1 and result_ready_in=0, psum_ready_out=0. acc/cnt hold, and upstream must hold its beat.
- Beat counter: wraps modulo 2^CNT_WIDTH. Vectors longer than that are illegal, with no detection.
- Accumulator overflow: wraps two's complement (see Optional Feature).
- psum_in values outside -9..+9 are processed arithmetically as given; no check.

Optional Feature:
- Macro: PSUM_SATURATE_EN.
- Defined:
  - Every add clamps to [-(2^(ACC_WIDTH-1)), 2^(ACC_WIDTH-1)-1].
  - Adds output port overflow_out (1 bit, sticky). It is set on any clamp and cleared only by reset_in.
- Undefined: two's-complement wraparound, and no overflow_out port.

Test Plan:
- Reset then 4 beats +9,+9,-3,+5 (last on the 4th), threshold=15 -> next cycle result_valid_out=1, acc_out=20, act_out=1, beat_count_out=4.
- Single beat -9 with last, threshold=-9 -> acc_out=-9, act_out=1 (equality counts), beat_count_out=1.
- Result held with result_ready_in=0 and psum_valid_in=1 for 5 cycles -> psum_ready_out=0, outputs stable. Raise result_ready_in -> consumed, next vector accepted the same cycle.
- Back-to-back 1-beat vectors (+3, -1) with result_ready_in=1 constantly -> results 3 then -1 on consecutive cycles, result_valid_out never drops.
- Reset asserted after 2 beats (+7,+7) of a vector, then new vector +1 (last), threshold=2 -> acc_out=1, act_out=0, beat_count_out=1.
- ACC_WIDTH=6, beats +9 x4 with last -> without PSUM_SATURATE_EN acc_out=-28 (36 wrapped); with it, acc_out=31 and overflow_out=1.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates signed 5-bit XNOR-popcount partial sums into one
// neuron's dot product. The beats of a vector are delimited by a last flag. On the
// last beat the block compares the sum against a per-neuron threshold and holds the
// result in an output register under a valid/ready handshake.
// Optional build macro: PSUM_SATURATE_EN. When defined, every add saturates and a
// sticky overflow_out port is added. When undefined, every add wraps.
module psum_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 psum_valid_in,
  input  logic [4:0]           psum_in,
  input  logic                 psum_last_in,
  input  logic [ACC_WIDTH-1:0] threshold_in,
  output logic                 psum_ready_out,
  output logic                 result_valid_out,
  input  logic                 result_ready_in,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 act_out,
  output logic [CNT_WIDTH-1:0] beat_count_out
`ifdef PSUM_SATURATE_EN
  ,
  output logic                 overflow_out
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_ACCUM = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        valid_q, valid_d;
  logic signed [ACC_WIDTH-1:0] res_acc_q, res_acc_d;
  logic                        act_q, act_d;
  logic        [CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;

  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic signed [ACC_WIDTH-1:0] thr_s;
  logic                        accept;
  logic                        consume;

`ifdef PSUM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic overflow_q, overflow_d;
  logic clamp;

  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] w;
    w = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (w[ACC_WIDTH] != w[ACC_WIDTH-1]) begin
      return w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    return w[ACC_WIDTH-1:0];
  endfunction

  function automatic logic add_clamps(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] w;
    w = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    return w[ACC_WIDTH] != w[ACC_WIDTH-1];
  endfunction
`endif

  assign psum_ext       = {{(ACC_WIDTH-5){psum_in[4]}}, psum_in};
  assign thr_s          = threshold_in;
  assign psum_ready_out = !valid_q || result_ready_in;
  assign accept         = psum_valid_in && psum_ready_out;
  assign consume        = valid_q && result_ready_in;
  // The first beat of a vector starts from zero, whatever the accumulator holds.
  assign base           = (state_q == ST_EMPTY) ? '0 : acc_q;

`ifdef PSUM_SATURATE_EN
  assign sum_next     = sat_add(base, psum_ext);
  assign clamp        = add_clamps(base, psum_ext);
  assign overflow_d   = overflow_q | (accept & clamp);
  assign overflow_out = overflow_q;
`else
  assign sum_next     = base + psum_ext;
`endif

  // Next-state: consume the held result, then fold in an accepted beat.
  // If a last beat arrives in the same cycle as a consume, its result replaces the
  // consumed one and valid stays high with no bubble.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    res_acc_d = res_acc_q;
    act_d     = act_q;
    res_cnt_d = res_cnt_q;
    if (consume) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (psum_last_in) begin
        res_acc_d = sum_next;
        act_d     = (sum_next >= thr_s);
        res_cnt_d = cnt_q + CNT_WIDTH'(1);
        valid_d   = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = ST_EMPTY;
      end else begin
        acc_d     = sum_next;
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        state_d   = ST_ACCUM;
      end
    end
  end

  // Registered state, accumulator and result register; reset clears all of them.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= ST_EMPTY;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      res_acc_q <= '0;
      act_q     <= 1'b0;
      res_cnt_q <= '0;
`ifdef PSUM_SATURATE_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      res_acc_q <= res_acc_d;
      act_q     <= act_d;
      res_cnt_q <= res_cnt_d;
`ifdef PSUM_SATURATE_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  assign result_valid_out = valid_q;
  assign acc_out          = res_acc_q;
  assign act_out          = act_q;
  assign beat_count_out   = res_cnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator: directed vectors, a queue-based reference model,
// and literal expectations. A second 6-bit instance exercises overflow behaviour.
module tb_psum_accumulator;
  localparam int AW = 16;
  localparam int CW = 12;
  localparam int SW = 6;
  localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW-1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, pv, plast, rr;
  logic [4:0]    psum;
  logic [AW-1:0] thr;
  logic          ready, rvalid, act;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  logic          s_pv, s_last;
  logic [4:0]    s_psum;
  logic [SW-1:0] s_thr;
  logic          s_ready, s_rvalid, s_act;
  logic [SW-1:0] s_acc;
  logic [CW-1:0] s_cnt;
`ifdef PSUM_SATURATE_EN
  logic          m_ovf, s_ovf;
`endif

  psum_accumulator #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_in(clk), .reset_in(rst), .psum_valid_in(pv), .psum_in(psum),
    .psum_last_in(plast), .threshold_in(thr), .psum_ready_out(ready),
    .result_valid_out(rvalid), .result_ready_in(rr), .acc_out(acc),
    .act_out(act), .beat_count_out(cnt)
`ifdef PSUM_SATURATE_EN
    , .overflow_out(m_ovf)
`endif
  );

  psum_accumulator #(.ACC_WIDTH(SW), .CNT_WIDTH(CW)) dut_small (
    .clk_in(clk), .reset_in(rst), .psum_valid_in(s_pv), .psum_in(s_psum),
    .psum_last_in(s_last), .threshold_in(s_thr), .psum_ready_out(s_ready),
    .result_valid_out(s_rvalid), .result_ready_in(1'b1), .acc_out(s_acc),
    .act_out(s_act), .beat_count_out(s_cnt)
`ifdef PSUM_SATURATE_EN
    , .overflow_out(s_ovf)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: collects the beats of the current vector in a queue and
  // evaluates the whole dot product when the last beat arrives.
  int     beats[$];
  bit     m_valid = 1'b0;
  longint m_acc = 0;
  bit     m_act = 1'b0;
  int     m_cnt = 0;
  bit     started = 1'b0;

  function automatic longint fold(input int q[$]);
    longint s = 0;
    foreach (q[i]) begin
      s += q[i];
`ifdef PSUM_SATURATE_EN
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
`endif
    end
`ifndef PSUM_SATURATE_EN
    s = s & ((longint'(1) << AW) - 1);
    if (s > MAXV) s -= (longint'(1) << AW);
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      beats.delete();
      m_valid = 1'b0;
      m_acc   = 0;
      m_act   = 1'b0;
      m_cnt   = 0;
      started = 1'b1;
    end else begin
      bit rdy;
      rdy = !m_valid || rr;
      if (m_valid && rr) m_valid = 1'b0;
      if (pv && rdy) begin
        beats.push_back(int'($signed(psum)));
        if (plast) begin
          m_acc   = fold(beats);
          m_act   = (m_acc >= longint'($signed(thr)));
          m_cnt   = beats.size() % (1 << CW);
          m_valid = 1'b1;
          beats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", ready, !m_valid || rr);
      chk("valid", rvalid, m_valid);
      if (m_valid) begin
        chk("acc", $signed(acc), m_acc);
        chk("act", act, m_act);
        chk("cnt", cnt, m_cnt);
      end
    end
  end

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic send(input int p, input bit last, input int t);
    bit r;
    bit ok = 1'b0;
    int n = 0;
    pv = 1'b1; psum = p[4:0]; plast = last; thr = t[AW-1:0];
    while (!ok && n < 64) begin
      #1 r = ready;
      @(posedge clk); #2;
      ok = r;
      n++;
    end
    pv = 1'b0; plast = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: beat %0d not accepted within %0d cycles", p, n);
    end
  endtask

  initial begin
    rst = 1'b1; pv = 1'b0; plast = 1'b0; psum = '0; thr = '0; rr = 1'b1;
    s_pv = 1'b0; s_last = 1'b0; s_psum = '0; s_thr = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", rvalid, 0);
    chk("rst_acc", $signed(acc), 0);
    chk("rst_act", act, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", ready, 1);

    // 4-beat vector, threshold 15
    send(9, 0, 0); send(9, 0, 0); send(-3, 0, 0); send(5, 1, 15);
    #1;
    chk("v1_valid", rvalid, 1);
    chk("v1_acc", $signed(acc), 20);
    chk("v1_act", act, 1);
    chk("v1_cnt", cnt, 4);

    // Single beat at threshold equality; overwrites the unconsumed result above
    send(-9, 1, -9);
    rr = 1'b0;
    #1;
    chk("v2_acc", $signed(acc), -9);
    chk("v2_act", act, 1);
    chk("v2_cnt", cnt, 1);

    // Stall: result held, upstream beat waiting
    pv = 1'b1; psum = 5'd4; plast = 1'b1; thr = '0;
    repeat (5) begin
      @(posedge clk); #3;
      chk("stall_ready", ready, 0);
      chk("stall_acc", $signed(acc), -9);
      chk("stall_valid", rvalid, 1);
    end
    rr = 1'b1;
    send(4, 1, 0);
    #1;
    chk("v3_acc", $signed(acc), 4);
    chk("v3_cnt", cnt, 1);

    // Back-to-back single-beat vectors
    send(3, 1, 0);
    #1 chk("b2b_acc0", $signed(acc), 3);
    send(-1, 1, 0);
    #1;
    chk("b2b_acc1", $signed(acc), -1);
    chk("b2b_act1", act, 0);
    chk("b2b_valid", rvalid, 1);

    // Threshold boundary: one below and exactly equal
    send(5, 1, 6);
    #1 chk("thr_below", act, 0);
    send(5, 1, 5);
    #1 chk("thr_equal", act, 1);

    // Long vector -9..+9, sum 0
    for (int v = -9; v <= 9; v++) send(v, v == 9, 0);
    #1;
    chk("long_acc", $signed(acc), 0);
    chk("long_act", act, 1);
    chk("long_cnt", cnt, 19);

    // Reset mid-vector discards the partial sum
    send(7, 0, 0); send(7, 0, 0);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("rst_mid_valid", rvalid, 0);
    send(1, 1, 2);
    #1;
    chk("rst_acc", $signed(acc), 1);
    chk("rst_act", act, 0);
    chk("rst_cnt", cnt, 1);

    // Narrow instance: +9 x4 overflows a 6-bit accumulator
    s_pv = 1'b1; s_psum = 5'd9; s_last = 1'b0; s_thr = '0;
    repeat (3) begin @(posedge clk); #2; end
    s_last = 1'b1;
    @(posedge clk); #2;
    s_pv = 1'b0; s_last = 1'b0;
    #1;
    chk("ovf_valid", s_rvalid, 1);
    chk("ovf_cnt", s_cnt, 4);
`ifdef PSUM_SATURATE_EN
    chk("ovf_acc", $signed(s_acc), 31);
    chk("ovf_act", s_act, 1);
    chk("ovf_flag", s_ovf, 1);
    chk("main_ovf", m_ovf, 0);
`else
    chk("ovf_acc", $signed(s_acc), -28);
    chk("ovf_act", s_act, 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
